// File: rtl/hms_button_ctrl.sv
// hms_button_ctrl -- button front-end for the hours/minutes/seconds watch core.
//
// Conditions four raw, bouncy, asynchronous push-buttons into clean,
// single-cycle, mutually exclusive command pulses.
//
// Pipeline per button: 2-FF synchronizer -> debouncer (stable level plus
// qualification counter) -> press-edge detector -> pending flag -> one shared
// priority arbiter (stop_run > next > inc > dec) -> registered output pulse.
//
// Optional feature: define AUTO_REPEAT_EN to add auto-repeat on inc/dec.
// The first repeat comes REPEAT_DELAY cycles after the press event, and later
// repeats come every REPEAT_PERIOD cycles while the button is held. When the
// macro is undefined, each press produces exactly one pulse.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous reset, active low
//   btn_stop_run  in   raw button, active high, asynchronous to clk
//   btn_next      in   raw button
//   btn_inc       in   raw button
//   btn_dec       in   raw button
//   stop_run      out  one-cycle command pulse
//   next          out  one-cycle command pulse
//   inc           out  one-cycle command pulse
//   dec           out  one-cycle command pulse
//   overrun       out  one-cycle pulse when an event merges into a pending one
module hms_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_stop_run,
  input  logic btn_next,
  input  logic btn_inc,
  input  logic btn_dec,
  output logic stop_run,
  output logic next,
  output logic inc,
  output logic dec,
  output logic overrun
);

  localparam int NB = 4;  // bit 0 stop_run, 1 next, 2 inc, 3 dec
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // The repeat reload value below assumes the period fits inside the delay.
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("hms_button_ctrl: need DEBOUNCE_CYCLES >= 1 and 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
  end

  logic [NB-1:0] w_raw;
  logic [NB-1:0] r_sync1, r_sync2;
  logic [NB-1:0] r_stable, r_stable_d;
  logic [DW-1:0] r_db_cnt [NB];
  logic [DW-1:0] w_db_cnt_nxt [NB];
  logic [NB-1:0] w_stable_nxt;
  logic [NB-1:0] w_accept;
  logic [NB-1:0] w_rpt_evt;
  logic [NB-1:0] w_evt;
  logic [NB-1:0] w_req;
  logic [NB-1:0] w_grant;
  logic [NB-1:0] r_pend;
  logic [NB-1:0] r_out;
  logic          r_overrun;

  assign w_raw = {btn_dec, btn_inc, btn_next, btn_stop_run};

  // Debounce: a differing level must be seen DEBOUNCE_CYCLES times in a row;
  // any cycle that matches the stable level restarts qualification.
  always_comb begin
    w_stable_nxt = r_stable;
    w_accept     = '0;
    for (int i = 0; i < NB; i++) begin
      w_db_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_stable[i]) begin
        if (r_db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          w_accept[i]     = 1'b1;
          w_stable_nxt[i] = r_sync2[i];
        end else begin
          w_db_cnt_nxt[i] = r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 2);

  logic [HW-1:0] r_hold [2];       // index 0 inc, 1 dec
  logic [HW-1:0] w_hold_nxt [2];
  logic [1:0]    w_rpt;
  logic          w_both;

  // Hold counter equals cycles since the press event. On reaching the delay it
  // reloads so that it returns to the delay value every REPEAT_PERIOD cycles.
  // A repeat falling in the cycle the debouncer accepts the release is dropped.
  always_comb begin
    w_both = r_stable[2] & r_stable[3];
    for (int i = 0; i < 2; i++) begin
      w_rpt[i]      = 1'b0;
      w_hold_nxt[i] = '0;
      if (r_stable[2+i] && !w_both) begin
        if (r_hold[i] == HW'(REPEAT_DELAY)) begin
          w_hold_nxt[i] = HW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
          w_rpt[i]      = ~w_accept[2+i];
        end else begin
          w_hold_nxt[i] = r_hold[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold[0] <= '0;
      r_hold[1] <= '0;
    end else begin
      r_hold[0] <= w_hold_nxt[0];
      r_hold[1] <= w_hold_nxt[1];
    end
  end

  assign w_rpt_evt = {w_rpt, 2'b00};
`else
  assign w_rpt_evt = '0;
`endif

  // Press is the stable rising edge; release produces nothing.
  assign w_evt   = (r_stable & ~r_stable_d) | w_rpt_evt;
  // Fresh events compete in the same cycle so an idle press is not delayed.
  assign w_req   = r_pend | w_evt;
  // Lowest set bit wins, which gives stop_run > next > inc > dec.
  assign w_grant = w_req & (~w_req + 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_pend     <= '0;
      r_out      <= '0;
      r_overrun  <= 1'b0;
      for (int i = 0; i < NB; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable   <= w_stable_nxt;
      r_stable_d <= r_stable;
      r_pend     <= w_req & ~w_grant;
      r_out      <= w_grant;
      r_overrun  <= |(w_evt & r_pend);
      for (int i = 0; i < NB; i++) r_db_cnt[i] <= w_db_cnt_nxt[i];
    end
  end

  assign stop_run = r_out[0];
  assign next     = r_out[1];
  assign inc      = r_out[2];
  assign dec      = r_out[3];
  assign overrun  = r_overrun;

endmodule
